// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding and
// the default debounce length.
package condicionador_botoes_pkg;

   typedef enum logic [1:0] {
      ESPERA    = 2'd0,
      PRONTO    = 2'd1,
      SEGURANDO = 2'd2
   } estado_t;

   localparam int N_BOTOES        = 4;
   localparam int DEBOUNCE_PADRAO = 50000;

endpackage

// File: rtl/condicionador_botoes_if.sv
// Button-side bundle between the raw inputs, the control unit and the game
// data path. The slave modport is the conditioner itself.
interface condicionador_botoes_if;
   import condicionador_botoes_pkg::*;

   logic [N_BOTOES-1:0] botoes_brutos;
   logic                habilita;
   logic [N_BOTOES-1:0] botoes_limpos;
   logic [N_BOTOES-1:0] jogada;
   logic                jogada_feita;
   logic                jogada_invalida;
   logic [1:0]          db_estado;

   modport master (
      output botoes_brutos, habilita,
      input  botoes_limpos, jogada, jogada_feita, jogada_invalida, db_estado
   );

   modport slave (
      input  botoes_brutos, habilita,
      output botoes_limpos, jogada, jogada_feita, jogada_invalida, db_estado
   );
endinterface

// File: rtl/condicionador_botoes_debounce_bit.sv
// One button lane: two-flop synchronizer followed by a counter that flips
// the filtered level only after DEBOUNCE_CICLOS consecutive disagreeing cycles.
module debounce_bit
   import condicionador_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
   input  logic clock,
   input  logic reset,
   input  logic i_bruto,
   output logic o_limpo
);

   localparam int CONT_W = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

   logic              r_meta;
   logic              r_sinc;
   logic              r_limpo;
   logic [CONT_W-1:0] r_cont;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sinc <= 1'b0;
      end else begin
         r_meta <= i_bruto;
         r_sinc <= r_meta;
      end
   end

   // Any cycle of agreement restarts the count, so glitches never accumulate.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cont  <= '0;
         r_limpo <= 1'b0;
      end else if (r_sinc == r_limpo) begin
         r_cont  <= '0;
      end else if (r_cont == CONT_MAX) begin
         r_cont  <= '0;
         r_limpo <= ~r_limpo;
      end else begin
         r_cont  <= r_cont + CONT_W'(1);
      end
   end

   assign o_limpo = r_limpo;

endmodule

// File: rtl/condicionador_botoes.sv
// Conditions the four game buttons and turns a clean single-button press
// into a one-cycle jogada_feita pulse with a held one-hot jogada code.
module condicionador_botoes
   import condicionador_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
   input  logic                  clock,
   input  logic                  reset,
   condicionador_botoes_if.slave bus
);

   logic [N_BOTOES-1:0] w_limpos;
   logic                w_algum;
   logic                w_varios;
   logic                w_unico;

   estado_t             r_estado;
   estado_t             w_prox_estado;
   logic [N_BOTOES-1:0] r_jogada;
   logic [N_BOTOES-1:0] w_prox_jogada;
   logic                r_feita;
   logic                w_prox_feita;
   logic                r_invalida;
   logic                w_prox_invalida;

   for (genvar g = 0; g < N_BOTOES; g++) begin : g_debounce
      debounce_bit #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_debounce (
         .clock   (clock),
         .reset   (reset),
         .i_bruto (bus.botoes_brutos[g]),
         .o_limpo (w_limpos[g])
      );
   end

   // Clearing the lowest set bit leaves something only when two or more are set.
   assign w_algum  = |w_limpos;
   assign w_varios = |(w_limpos & (w_limpos - 4'd1));
   assign w_unico  = w_algum & ~w_varios;

   always_comb begin
      w_prox_estado   = r_estado;
      w_prox_jogada   = r_jogada;
      w_prox_feita    = 1'b0;
      w_prox_invalida = 1'b0;
      case (r_estado)
         ESPERA: begin
            if (!w_algum && bus.habilita) begin
               w_prox_estado = PRONTO;
            end else begin
               w_prox_estado = ESPERA;
            end
         end
         PRONTO: begin
            if (!bus.habilita) begin
               w_prox_estado = ESPERA;
            end else if (w_unico) begin
               w_prox_estado = SEGURANDO;
               w_prox_jogada = w_limpos;
               w_prox_feita  = 1'b1;
            end else if (w_varios) begin
               w_prox_estado   = SEGURANDO;
               w_prox_invalida = 1'b1;
            end else begin
               w_prox_estado = PRONTO;
            end
         end
         SEGURANDO: begin
            if (!w_algum) begin
               w_prox_estado = ESPERA;
            end else begin
               w_prox_estado = SEGURANDO;
            end
         end
         default: begin
            w_prox_estado = ESPERA;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado   <= ESPERA;
         r_jogada   <= 4'd0;
         r_feita    <= 1'b0;
         r_invalida <= 1'b0;
      end else begin
         r_estado   <= w_prox_estado;
         r_jogada   <= w_prox_jogada;
         r_feita    <= w_prox_feita;
         r_invalida <= w_prox_invalida;
      end
   end

   assign bus.botoes_limpos   = w_limpos;
   assign bus.jogada          = r_jogada;
   assign bus.jogada_feita    = r_feita;
   assign bus.jogada_invalida = r_invalida;
   assign bus.db_estado       = r_estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed scenarios plus randomized button traffic, each cycle compared
// against a window-based behavioural model of the conditioner.
module tb_condicionador_botoes;

   localparam int D = 4;

   logic clock = 1'b0;
   logic reset;
   condicionador_botoes_if bus ();

   condicionador_botoes #(.DEBOUNCE_CICLOS(D)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model state
   logic [3:0] m_raw_q[$];
   logic [3:0] m_janela[$];
   logic [3:0] m_filt;
   logic [3:0] m_jog;
   logic       m_feita;
   logic       m_inval;
   int         m_modo;

   // observation counters for directed scenarios
   int n_feita;
   int n_inval;
   int cyc_feita;
   bit viu_limpos;
   bit viu_espera;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_raw_q.delete();
      m_raw_q.push_back(4'd0);
      m_raw_q.push_back(4'd0);
      m_janela.delete();
      m_filt  = 4'd0;
      m_jog   = 4'd0;
      m_feita = 1'b0;
      m_inval = 1'b0;
      m_modo  = 0;
   endtask

   task automatic model_edge();
      logic [3:0] s;
      logic [3:0] v;
      logic [3:0] nf;
      int         n;
      bit         todos;
      if (reset) begin
         model_reset();
         return;
      end
      s = m_raw_q.pop_front();
      m_raw_q.push_back(bus.botoes_brutos);
      n = $countones(m_filt);
      m_feita = 1'b0;
      m_inval = 1'b0;
      if (m_modo == 0) begin
         if (n == 0 && bus.habilita) m_modo = 1;
      end else if (m_modo == 1) begin
         if (!bus.habilita) m_modo = 0;
         else if (n == 1) begin m_jog = m_filt; m_feita = 1'b1; m_modo = 2; end
         else if (n > 1) begin m_inval = 1'b1; m_modo = 2; end
      end else begin
         if (n == 0) m_modo = 0;
      end
      // a filtered bit flips once the last D synchronized samples all disagree
      m_janela.push_back(s);
      if (m_janela.size() > D) void'(m_janela.pop_front());
      nf = m_filt;
      for (int b = 0; b < 4; b++) begin
         todos = (m_janela.size() == D);
         foreach (m_janela[k]) begin
            v = m_janela[k];
            if (v[b] == m_filt[b]) todos = 0;
         end
         if (todos) nf[b] = ~m_filt[b];
      end
      m_filt = nf;
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      cyc++;
      chk("limpos", bus.botoes_limpos, m_filt);
      chk("jogada", bus.jogada, m_jog);
      chk("feita", {3'd0, bus.jogada_feita}, {3'd0, m_feita});
      chk("invalida", {3'd0, bus.jogada_invalida}, {3'd0, m_inval});
      chk("estado", {2'd0, bus.db_estado}, 4'(m_modo));
      if (bus.jogada_feita) begin n_feita++; cyc_feita = cyc; end
      if (bus.jogada_invalida) n_inval++;
      if (bus.botoes_limpos != 4'd0) viu_limpos = 1;
      if (bus.db_estado == 2'd0) viu_espera = 1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic limpa_obs();
      n_feita = 0; n_inval = 0; cyc_feita = -1; viu_limpos = 0; viu_espera = 0;
   endtask

   initial begin
      int inicio;
      int dur;
      logic [3:0] r;
      model_reset();
      limpa_obs();
      reset = 1'b1;
      bus.botoes_brutos = 4'b0010;
      bus.habilita = 1'b1;

      // reset held with a button down
      run(3);
      chk("rst_limpos", bus.botoes_limpos, 4'd0);
      chk("rst_jogada", bus.jogada, 4'd0);
      chk("rst_pulsos", {2'd0, bus.jogada_feita, bus.jogada_invalida}, 4'd0);
      chk("rst_estado", {2'd0, bus.db_estado}, 4'd0);
      reset = 1'b0;
      inicio = cyc;
      limpa_obs();
      run(20);
      chk("rst_lat", 4'(cyc_feita - inicio), 4'd7);
      chk("rst_jog", bus.jogada, 4'b0010);
      bus.botoes_brutos = 4'd0;
      run(15);

      // clean press on bit 2
      limpa_obs();
      inicio = cyc;
      bus.botoes_brutos = 4'b0100;
      run(20);
      chk("limpa_lat", 4'(cyc_feita - inicio), 4'd7);
      chk("limpa_n", 4'(n_feita), 4'd1);
      bus.botoes_brutos = 4'd0;
      run(15);
      chk("limpa_jog", bus.jogada, 4'b0100);

      // 3-cycle glitch on bit 0
      limpa_obs();
      bus.botoes_brutos = 4'b0001;
      run(3);
      bus.botoes_brutos = 4'd0;
      run(15);
      chk("glitch_limpos", {3'd0, viu_limpos}, 4'd0);
      chk("glitch_pulsos", 4'(n_feita + n_inval), 4'd0);

      // simultaneous bits 0 and 3
      limpa_obs();
      bus.botoes_brutos = 4'b1001;
      run(15);
      chk("simul_inval", 4'(n_inval), 4'd1);
      chk("simul_feita", 4'(n_feita), 4'd0);
      chk("simul_jog", bus.jogada, 4'b0100);
      bus.botoes_brutos = 4'd0;
      run(15);

      // staggered: bit 1 then bit 3 while holding
      limpa_obs();
      bus.botoes_brutos = 4'b0010;
      run(5);
      bus.botoes_brutos = 4'b1010;
      run(20);
      chk("stag_n", 4'(n_feita + n_inval), 4'd1);
      chk("stag_jog", bus.jogada, 4'b0010);
      viu_espera = 0;
      bus.botoes_brutos = 4'd0;
      run(15);
      chk("stag_espera", {3'd0, viu_espera}, 4'd1);

      // habilita gating
      limpa_obs();
      bus.habilita = 1'b0;
      bus.botoes_brutos = 4'b0001;
      run(10);
      bus.habilita = 1'b1;
      run(15);
      chk("hab_nada", 4'(n_feita + n_inval), 4'd0);
      bus.botoes_brutos = 4'd0;
      run(15);
      bus.botoes_brutos = 4'b0001;
      run(15);
      chk("hab_n", 4'(n_feita), 4'd1);
      chk("hab_jog", bus.jogada, 4'b0001);
      bus.botoes_brutos = 4'd0;
      run(12);

      // randomized traffic
      for (int s = 0; s < 200; s++) begin
         r = 4'($urandom_range(0, 15));
         bus.botoes_brutos = ($urandom_range(0, 1) == 0) ? 4'd0 : r;
         bus.habilita = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b1;
            run(2);
            reset = 1'b0;
         end
         dur = $urandom_range(1, 12);
         run(dur);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
Upstream input stage for the game circuit. It conditions the four raw push-button inputs: two-flop synchronization, per-button debounce, and press detection. It emits a single-cycle "jogada_feita" pulse together with a stable registered one-hot code. The game data path samples that code as its "botoes" input. Simultaneous multi-button presses are rejected and flagged.

Parameters:
DEBOUNCE_CICLOS, 50000, number of consecutive clock cycles a synchronized input must differ from its filtered value before the filtered value flips (1 ms at 50 MHz); legal range >= 2.
CONT_W, $clog2(DEBOUNCE_CICLOS), width of each debounce counter (derived, not overridden).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
botoes_brutos  input  4  raw, asynchronous button levels, 1 = pressed.
habilita  input  1  from the control unit (vez_jogador). When low, no press pulses are generated.
botoes_limpos  output  4  debounced level of each button.
jogada  output  4  one-hot code of the last valid press; held until the next valid press.
jogada_feita  output  1  single-cycle pulse on a valid single-button press.
jogada_invalida  output  1  single-cycle pulse when more than one filtered bit rises in the same cycle.
db_estado  output  2  current FSM state code, for debug.

Behaviour:
- Reset (asynchronous): clears all sync flops, counters, botoes_limpos, jogada, pulses, and the state. State goes to ESPERA, db_estado = 0.
- Sync: two flops per bit. sinc[i] is the raw value delayed by 2 edges.
- Debounce, per bit and independent:
  - If sinc[i] == botoes_limpos[i], the counter clears.
  - Otherwise the counter increments.
  - When the counter = DEBOUNCE_CICLOS-1 and the bit still differs, botoes_limpos[i] toggles at the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CICLOS cycles never changes botoes_limpos. Any return to equality resets the count.
- FSM on botoes_limpos (registered outputs, Moore-style pulses):
  - ESPERA (0):
    - botoes_limpos == 0 and habilita = 1 -> go to PRONTO.
    - Otherwise stay.
  - PRONTO (1):
    - habilita = 0 -> go to ESPERA.
    - Exactly one bit set -> latch jogada <= botoes_limpos, pulse jogada_feita for one cycle, go to SEGURANDO.
    - Two or more bits set -> pulse jogada_invalida for one cycle, jogada unchanged, go to SEGURANDO.
    - Zero bits set -> stay.
  - SEGURANDO (2):
    - Wait until botoes_limpos == 0, then go to ESPERA.
    - Extra buttons pressed while here are ignored. No pulses are generated.
- Latency: raw press stable from edge t -> botoes_limpos rises at edge t+2+DEBOUNCE_CICLOS -> pulse high for the cycle after edge t+3+DEBOUNCE_CICLOS (when the FSM is already in PRONTO).
- A button held while habilita is low, or held across a rise of habilita, produces no pulse. It must be released and pressed again.
- Presses that become filtered in different cycles: the first single press is valid; later ones are ignored in SEGURANDO.
- jogada_feita and jogada_invalida are never high in the same cycle, and never high two cycles in a row.
- Reset while a button is held: after reset the filtered value is 0. The held button is then re-debounced and yields a pulse if habilita = 1.

Decomposition:
- The shared package holds:
  - the state encoding (ESPERA=2'd0, PRONTO=2'd1, SEGURANDO=2'd2);
  - the default debounce constant.
- One sub-module is natural: debounce_bit. It holds the 2-FF sync, the counter, and the filtered flop for one bit, with parameter DEBOUNCE_CICLOS. It is instantiated 4x via generate.
- The one-hot check (popcount == 1) stays in the top module.

Test Plan:
- Reset: hold reset with botoes_brutos=4'b0010 -> all outputs 0, db_estado=0; after release with habilita=1 and DEBOUNCE_CICLOS=4 -> jogada=4'b0010 and jogada_feita pulse 7 cycles after the first post-reset edge.
- Clean press: habilita=1, raise bit 2 for 20 cycles (DEBOUNCE_CICLOS=4) -> exactly one jogada_feita pulse, 7 edges after the rise; jogada=4'b0100 held after release.
- Glitch: 3-cycle pulse on bit 0 (DEBOUNCE_CICLOS=4) -> botoes_limpos stays 0, no pulses.
- Simultaneous: raise bits 0 and 3 on the same edge -> one jogada_invalida pulse, jogada unchanged, no jogada_feita until both are released and a new single press occurs.
- Staggered/hold: press bit 1, then bit 3 five cycles later while bit 1 is held -> single jogada_feita with jogada=4'b0010, nothing for bit 3; release all -> back to ESPERA.
- Habilita gating: press bit 0 with habilita=0 and raise habilita mid-hold -> no pulse; release and press again -> pulse, jogada=4'b0001.
